// File: rtl/uart_rx_fifo_pkg.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo_pkg
// Shared constants and helpers for the UART receive buffer.
//   UART_DATA_W      payload width of the receiver data bus
//   UART_STAT_*      bit positions of the RX status flags as seen by the APB
//                    register block
//   ERRTAG_EN        1 when UART_RX_FIFO_ERRTAG_EN is defined (entries carry
//                    an error tag bit), 0 otherwise
//   irq_hit()        threshold compare shared by the RTL
// Optional feature macro: UART_RX_FIFO_ERRTAG_EN
// -----------------------------------------------------------------------------
package uart_rx_fifo_pkg;

    localparam int UART_DATA_W    = 8;

    // Status register bit positions
    localparam int UART_STAT_OVR  = 0;
    localparam int UART_STAT_FERR = 1;
    localparam int UART_STAT_RXNE = 2;

`ifdef UART_RX_FIFO_ERRTAG_EN
    localparam int ERRTAG_EN = 1;
`else
    localparam int ERRTAG_EN = 0;
`endif

    // Packed view of the status flags, ordered to match UART_STAT_* positions
    typedef struct packed {
        logic rxne;
        logic ferr;
        logic ovr;
    } uart_rx_stat_t;

    // Threshold interrupt condition: a zero threshold disables the interrupt,
    // and a threshold above the FIFO depth can never be reached.
    function automatic logic irq_hit(input int unsigned lvl, input int unsigned thr);
        return (thr != 0) && (lvl >= thr);
    endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo_if
// Groups the receiver-side capture signals, the register-side pop/status
// signals and the FIFO outputs of uart_rx_fifo.
//   master : driven by the receiver / register block (testbench)
//   slave  : used by uart_rx_fifo
// Signals:
//   rx_done, rx_err, rx_data    receiver levels and byte
//   rd_en, clr_status, thr      pop strobe, sticky clear, irq threshold
//   rd_data, rd_valid, full,    FIFO head and occupancy
//   level
//   overrun, frame_err, irq     status outputs
//   rd_err                      head error tag (UART_RX_FIFO_ERRTAG_EN only)
// Optional feature macro: UART_RX_FIFO_ERRTAG_EN
// -----------------------------------------------------------------------------
interface uart_rx_fifo_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    logic              rx_done;
    logic              rx_err;
    logic [DATA_W-1:0] rx_data;
    logic              rd_en;
    logic              clr_status;
    logic [ADDR_W:0]   thr;

    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              full;
    logic [ADDR_W:0]   level;
    logic              overrun;
    logic              frame_err;
    logic              irq;
`ifdef UART_RX_FIFO_ERRTAG_EN
    logic              rd_err;
`endif

    modport master (
        output rx_done, rx_err, rx_data, rd_en, clr_status, thr,
`ifdef UART_RX_FIFO_ERRTAG_EN
        input  rd_err,
`endif
        input  rd_data, rd_valid, full, level, overrun, frame_err, irq
    );

    modport slave (
        input  rx_done, rx_err, rx_data, rd_en, clr_status, thr,
`ifdef UART_RX_FIFO_ERRTAG_EN
        output rd_err,
`endif
        output rd_data, rd_valid, full, level, overrun, frame_err, irq
    );

endinterface

// File: rtl/uart_fifo_ram.sv
// -----------------------------------------------------------------------------
// uart_fifo_ram
// 2**ADDR_W x WIDTH register array: synchronous write, asynchronous read.
// The asynchronous read gives the FIFO its fall-through behaviour: the head
// entry is visible on rdata as soon as the read pointer points at it.
// Ports:
//   clk    in   system clock
//   we     in   write enable
//   waddr  in   write address
//   wdata  in   write data
//   raddr  in   read address
//   rdata  out  combinational read data at raddr
// -----------------------------------------------------------------------------
module uart_fifo_ram #(
    parameter int ADDR_W = 4,
    parameter int WIDTH  = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);
    localparam int DEPTH = 1 << ADDR_W;

    // Storage has no reset: contents are only observed once written.
    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo
// Downstream buffer for the UART receiver. Each 0->1 edge of rx_done captures
// rx_data into a 2**ADDR_W-entry first-word-fall-through FIFO read by the APB
// register block. Tracks sticky overrun / framing-error flags and drives a
// registered level interrupt at a programmable fill threshold.
// Ports:
//   clk     in   system clock
//   arst_n  in   asynchronous active-low reset
//   rst     in   synchronous clear, same effect as arst_n
//   bus     slave modport of uart_rx_fifo_if (capture inputs, pop/clear/thr,
//                FIFO head, level, full, overrun, frame_err, irq, rd_err)
// Optional feature macro: UART_RX_FIFO_ERRTAG_EN
//   defined   : entries are {tag, data}; an rx_err edge pushes rx_data with
//               tag=1 under the same full/overrun rules; rd_err shows the tag
//   undefined : entries are data only; erroneous bytes are discarded
// -----------------------------------------------------------------------------
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int DATA_W = UART_DATA_W
) (
    input  logic          clk,
    input  logic          arst_n,
    input  logic          rst,
    uart_rx_fifo_if.slave bus
);
    localparam int              DEPTH   = 1 << ADDR_W;
    localparam int              ENTRY_W = DATA_W + ERRTAG_EN;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    // Edge-detect history
    logic              done_q;
    logic              err_q;

    // Pointers, occupancy and flags
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   level_q,  level_d;
    logic              overrun_q,   overrun_d;
    logic              frame_err_q, frame_err_d;
    logic              irq_q,       irq_d;

    // Per-cycle events
    logic               push_ev;
    logic               err_ev;
    logic               wr_req;
    logic               is_full;
    logic               not_empty;
    logic               pop;
    logic               push;
    logic [ENTRY_W-1:0] wr_entry;
    logic [ENTRY_W-1:0] rd_entry;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        push_ev   = bus.rx_done & ~done_q;
        err_ev    = bus.rx_err  & ~err_q;

`ifdef UART_RX_FIFO_ERRTAG_EN
        // A good edge and a bad edge in the same cycle describe one byte;
        // store it once, tagged as erroneous.
        wr_req    = push_ev | err_ev;
        wr_entry  = {err_ev, bus.rx_data};
`else
        wr_req    = push_ev;
        wr_entry  = bus.rx_data;
`endif

        is_full   = (level_q == DEPTH_L);
        not_empty = (level_q != '0);

        // Pop on an empty FIFO is silently ignored.
        pop       = bus.rd_en & not_empty;
        // When full, a simultaneous pop frees the slot being written: wr_ptr
        // equals rd_ptr, the head is read combinationally before the edge.
        push      = wr_req & (~is_full | pop);

        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        level_d   = level_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        end
        case ({push, pop})
            2'b10:   level_d = level_q + (ADDR_W + 1)'(1);
            2'b01:   level_d = level_q - (ADDR_W + 1)'(1);
            default: level_d = level_q;
        endcase

        // Sticky flags: clear first so a same-cycle set wins.
        overrun_d   = overrun_q;
        frame_err_d = frame_err_q;
        if (bus.clr_status) begin
            overrun_d   = 1'b0;
            frame_err_d = 1'b0;
        end
        if (wr_req && is_full && !pop) begin
            overrun_d = 1'b1;
        end
        if (err_ev) begin
            frame_err_d = 1'b1;
        end

        irq_d = irq_hit(32'(level_d), 32'(bus.thr));
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    // done_q/err_q reset to 1 so a receiver level already high when reset
    // releases is not mistaken for a fresh edge.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            done_q      <= 1'b1;
            err_q       <= 1'b1;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
            irq_q       <= 1'b0;
        end else if (rst) begin
            done_q      <= 1'b1;
            err_q       <= 1'b1;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            done_q      <= bus.rx_done;
            err_q       <= bus.rx_err;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
            irq_q       <= irq_d;
        end
    end

    // -------------------------------------------------------------------------
    // Storage
    // -------------------------------------------------------------------------
    // The write is qualified by reset so an edge arriving in a reset cycle
    // leaves no trace, keeping storage consistent with the cleared pointers.
    uart_fifo_ram #(
        .ADDR_W (ADDR_W),
        .WIDTH  (ENTRY_W)
    ) u_ram (
        .clk   (clk),
        .we    (push & ~rst),
        .waddr (wr_ptr_q),
        .wdata (wr_entry),
        .raddr (rd_ptr_q),
        .rdata (rd_entry)
    );

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign bus.rd_data   = rd_entry[DATA_W-1:0];
    assign bus.rd_valid  = not_empty;
    assign bus.full      = is_full;
    assign bus.level     = level_q;
    assign bus.overrun   = overrun_q;
    assign bus.frame_err = frame_err_q;
    assign bus.irq       = irq_q;
`ifdef UART_RX_FIFO_ERRTAG_EN
    assign bus.rd_err    = rd_entry[DATA_W];
`endif

endmodule
